// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: bundle between the LSU-side I/O register and the LCD controller.
//   io_lcd      : command word written by software (ON, BLON, CLR_OVF, GO, RS, DATA)
//   lcd_status  : status word readable by software (busy, overflow, write count)
//   lcd_on/blon : panel power and backlight
//   lcd_en/rs/rw: LCD bus control, lcd_data: LCD data bus
// master = LSU / bench side, slave = controller side.
interface lcd_ctrl_if;
    logic [31:0] io_lcd;
    logic [31:0] lcd_status;
    logic        lcd_on;
    logic        lcd_blon;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    modport master (
        output io_lcd,
        input  lcd_status, lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw, lcd_data
    );

    modport slave (
        input  io_lcd,
        output lcd_status, lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw, lcd_data
    );
endinterface

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: character-LCD write-cycle generator behind the io_lcd register.
// Detects GO rising edges in io_lcd, buffers one pending command, and drives
// the 8-bit parallel write cycle (setup, enable pulse, hold, execution wait).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lcd_ctrl_if.slave (io_lcd in; lcd_status, lcd_on, lcd_blon,
//              lcd_en, lcd_rs, lcd_rw, lcd_data out)
// Optional feature: define LCD_INIT_EN to issue the panel init sequence
// 0x38, 0x0C, 0x01, 0x06 automatically after reset release.
module lcd_ctrl #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000,
    parameter int unsigned T_CLEAR = 82000
) (
    input  logic       clk,
    input  logic       rst,
    lcd_ctrl_if.slave  bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max2(max2(T_SETUP, T_EN), max2(max2(T_HOLD, T_EXEC), T_CLEAR));
    localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

`ifdef LCD_INIT_EN
    localparam logic [2:0] INIT_N = 3'd4;
`else
    localparam logic [2:0] INIT_N = 3'd0;
`endif

    // Init command selected by number of init commands still to issue.
    function automatic logic [7:0] init_cmd(input logic [2:0] pend);
        case (pend)
            3'd4:    return 8'h38;
            3'd3:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             go_q, clr_q;
    logic             buf_valid, buf_valid_n;
    logic             buf_rs, buf_rs_n;
    logic [7:0]       buf_data, buf_data_n;
    logic             ovf_q, ovf_n;
    logic             busy_q, busy_n;
    logic [7:0]       done_q, done_n;
    logic [2:0]       init_pend, init_pend_n;
    logic             init_run, init_run_n;
    logic             en_q;
    logic             rs_q, rs_n;
    logic [7:0]       data_q, data_n;
    logic             on_q, blon_q;

    logic go_req, clr_req, is_clear, cmd_end, can_start;
    logic take_init, take_buf, take_req, buf_free;

    // Io_lcd bits with no function in this block.
    logic unused_bits;
    assign unused_bits = ^{bus.io_lcd[29:13], bus.io_lcd[10], bus.io_lcd[8]};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            go_q      <= 1'b0;
            clr_q     <= 1'b0;
            buf_valid <= 1'b0;
            buf_rs    <= 1'b0;
            buf_data  <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= '0;
            init_pend <= INIT_N;
            init_run  <= 1'b0;
            en_q      <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= '0;
            on_q      <= 1'b0;
            blon_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            go_q      <= bus.io_lcd[11];
            clr_q     <= bus.io_lcd[12];
            buf_valid <= buf_valid_n;
            buf_rs    <= buf_rs_n;
            buf_data  <= buf_data_n;
            ovf_q     <= ovf_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            init_pend <= init_pend_n;
            init_run  <= init_run_n;
            en_q      <= (state_n == S_PULSE);
            rs_q      <= rs_n;
            data_q    <= data_n;
            on_q      <= bus.io_lcd[31];
            blon_q    <= bus.io_lcd[30];
        end
    end

    // Next-state, buffer, overflow and counter logic.
    always_comb begin
        state_n     = state;
        cnt_n       = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        buf_valid_n = buf_valid;
        buf_rs_n    = buf_rs;
        buf_data_n  = buf_data;
        ovf_n       = ovf_q;
        done_n      = done_q;
        init_pend_n = init_pend;
        init_run_n  = init_run;
        rs_n        = rs_q;
        data_n      = data_q;

        go_req    = bus.io_lcd[11] & ~go_q;
        clr_req   = bus.io_lcd[12] & ~clr_q;
        is_clear  = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));
        cmd_end   = (state == S_EXEC) && (cnt == '0);
        can_start = (state == S_IDLE) || cmd_end;
        // Priority at a start opportunity: init sequence, buffer, fresh request.
        take_init = can_start && (init_pend != 3'd0);
        take_buf  = can_start && !take_init && buf_valid;
        take_req  = can_start && !take_init && !buf_valid && go_req;
        buf_free  = !buf_valid || take_buf;

        unique case (state)
            S_SETUP: if (cnt == '0) begin
                state_n = S_PULSE;
                cnt_n   = CNT_W'(T_EN - 1);
            end
            S_PULSE: if (cnt == '0) begin
                state_n = S_HOLD;
                cnt_n   = CNT_W'(T_HOLD - 1);
            end
            S_HOLD: if (cnt == '0) begin
                state_n = S_EXEC;
                cnt_n   = is_clear ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
            end
            S_EXEC: if (cnt == '0) begin
                state_n = S_IDLE;
            end
            default: ;
        endcase

        // Init commands never count as completed writes.
        if (cmd_end && !init_run) begin
            done_n = done_q + 8'd1;
        end

        if (take_init || take_buf || take_req) begin
            state_n = S_SETUP;
            cnt_n   = CNT_W'(T_SETUP - 1);
        end

        if (take_init) begin
            rs_n        = 1'b0;
            data_n      = init_cmd(init_pend);
            init_pend_n = init_pend - 3'd1;
            init_run_n  = 1'b1;
        end else if (take_buf) begin
            rs_n        = buf_rs;
            data_n      = buf_data;
            buf_valid_n = 1'b0;
            init_run_n  = 1'b0;
        end else if (take_req) begin
            rs_n        = bus.io_lcd[9];
            data_n      = bus.io_lcd[7:0];
            init_run_n  = 1'b0;
        end

        if (clr_req) begin
            ovf_n = 1'b0;
        end

        // A request not started directly goes to the buffer if it is (or is becoming) free.
        if (go_req && !take_req) begin
            if (buf_free) begin
                buf_valid_n = 1'b1;
                buf_rs_n    = bus.io_lcd[9];
                buf_data_n  = bus.io_lcd[7:0];
            end else begin
                ovf_n = 1'b1;
            end
        end

        busy_n = (state_n != S_IDLE) || buf_valid_n;
    end

    assign bus.lcd_status = {16'd0, done_q, 6'd0, ovf_q, busy_q};
    assign bus.lcd_on     = on_q;
    assign bus.lcd_blon   = blon_q;
    assign bus.lcd_en     = en_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl. Expected LCD writes are queued
// when GO is driven and compared as each EN pulse completes; timing and status
// are checked at fixed cycle offsets from the GO edge.
module tb_lcd_ctrl;

    localparam int unsigned T_SETUP = 2;
    localparam int unsigned T_EN    = 4;
    localparam int unsigned T_HOLD  = 2;
    localparam int unsigned T_EXEC  = 10;
    localparam int unsigned T_CLEAR = 50;

    logic clk = 1'b0;
    logic rst;

    lcd_ctrl_if bus ();

    lcd_ctrl #(
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_EXEC  (T_EXEC),
        .T_CLEAR (T_CLEAR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] sb[$];
    logic [31:0] en_mask, busy_mask;
    int         gaps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_go(input logic rs, input logic [7:0] data);
        bus.io_lcd[11]  = 1'b1;
        bus.io_lcd[9]   = rs;
        bus.io_lcd[7:0] = data;
    endtask

    // EN-pulse monitor: pops the scoreboard when a pulse completes.
    logic       mon_in = 1'b0;
    logic [8:0] mon_cmd;
    int         mon_w;
    always @(negedge clk) begin
        if (rst) begin
            mon_in = 1'b0;
        end else if (bus.lcd_en) begin
            if (!mon_in) begin
                mon_in  = 1'b1;
                mon_w   = 0;
                mon_cmd = {bus.lcd_rs, bus.lcd_data};
            end
            mon_w++;
        end else if (mon_in) begin
            mon_in = 1'b0;
            if (sb.size() == 0) begin
                check("sb_unexpected_write", 32'(sb.size()), 32'd1);
            end else begin
                check("sb_write_cmd", 32'(mon_cmd), 32'(sb.pop_front()));
                check("sb_en_width", 32'(mon_w), 32'(T_EN));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        bus.io_lcd = '0;
        #12;
        check("rst_status", bus.lcd_status, 32'd0);
        check("rst_pins", 32'({bus.lcd_on, bus.lcd_blon, bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef LCD_INIT_EN
        // Init sequence after reset release, with one user request queued during it.
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h06});
        sb.push_back({1'b1, 8'h55});
        gaps = 0;
        for (int k = 1; k <= 131; k++) begin
            tick(1);
            if (k <= 130 && bus.lcd_status[0] == 1'b0) gaps++;
            if (k == 5) drive_go(1'b1, 8'h55);
            if (k == 6) bus.io_lcd[11] = 1'b0;
            if (k == 113) check("init_count_after_init", 32'(bus.lcd_status[15:8]), 32'd0);
            if (k == 113) check("init_user_data", 32'(bus.lcd_data), 32'h55);
            if (k == 131) begin
                check("init_busy_end", 32'(bus.lcd_status[0]), 32'd0);
                check("init_count_end", 32'(bus.lcd_status[15:8]), 32'd1);
            end
        end
        check("init_busy_gaps", 32'(gaps), 32'd0);
`else
        // Power/backlight: one-cycle registered copy.
        bus.io_lcd[31:30] = 2'b10;
        check("on_latency", 32'({bus.lcd_on, bus.lcd_blon}), 32'd0);
        tick(1);
        check("on_blon", 32'({bus.lcd_on, bus.lcd_blon}), 32'b10);

        // Single data write: EN window, busy window, data/rs, count.
        drive_go(1'b1, 8'h41);
        sb.push_back({1'b1, 8'h41});
        en_mask   = '0;
        busy_mask = '0;
        for (int k = 0; k <= 20; k++) begin
            en_mask[k]   = bus.lcd_en;
            busy_mask[k] = bus.lcd_status[0];
            if (k == 1) check("t1_rs_data", 32'({bus.lcd_rs, bus.lcd_data}), 32'h141);
            if (k == 19) check("t1_count", 32'(bus.lcd_status[15:8]), 32'd1);
            tick(1);
            if (k == 0) bus.io_lcd[11] = 1'b0;
        end
        check("t1_en_window", en_mask, 32'h0000_0078);
        check("t1_busy_window", busy_mask, 32'h0007_FFFE);
        check("t1_idle_data_hold", 32'({bus.lcd_rs, bus.lcd_data}), 32'h141);

        // Clear command uses the long execution wait.
        drive_go(1'b0, 8'h01);
        sb.push_back({1'b0, 8'h01});
        tick(1);
        bus.io_lcd[11] = 1'b0;
        tick(57);
        check("t2_busy_n58", 32'(bus.lcd_status[0]), 32'd1);
        tick(1);
        check("t2_busy_n59", 32'(bus.lcd_status[0]), 32'd0);
        check("t2_count", 32'(bus.lcd_status[15:8]), 32'd2);

        // Three GO edges in one transaction: buffer, back-to-back, overflow.
        drive_go(1'b1, 8'h50);
        sb.push_back({1'b1, 8'h50});
        tick(1);
        bus.io_lcd[11] = 1'b0;
        tick(1);
        drive_go(1'b1, 8'h51);
        sb.push_back({1'b1, 8'h51});
        tick(1);
        bus.io_lcd[11] = 1'b0;
        check("t3_ovf_after_buffered", 32'(bus.lcd_status[1]), 32'd0);
        tick(1);
        drive_go(1'b1, 8'h52);
        tick(1);
        bus.io_lcd[11] = 1'b0;
        check("t3_ovf_set", 32'(bus.lcd_status[1]), 32'd1);
        tick(13);
        check("t3_count_n18", 32'(bus.lcd_status[15:8]), 32'd2);
        tick(1);
        check("t3_b2b_data", 32'({bus.lcd_rs, bus.lcd_data}), 32'h151);
        check("t3_count_n19", 32'(bus.lcd_status[15:8]), 32'd3);
        check("t3_busy_n19", 32'(bus.lcd_status[0]), 32'd1);
        tick(18);
        check("t3_busy_n37", 32'(bus.lcd_status[0]), 32'd0);
        check("t3_count_n37", 32'(bus.lcd_status[15:8]), 32'd4);
        check("t3_ovf_sticky", 32'(bus.lcd_status[1]), 32'd1);
        bus.io_lcd[12] = 1'b1;
        check("t3_ovf_clr_latency", 32'(bus.lcd_status[1]), 32'd1);
        tick(1);
        bus.io_lcd[12] = 1'b0;
        check("t3_ovf_cleared", 32'(bus.lcd_status[1]), 32'd0);
        tick(2);

        // Reset during PULSE aborts the write immediately.
        drive_go(1'b1, 8'h60);
        tick(1);
        bus.io_lcd[11] = 1'b0;
        tick(3);
        check("t4_en_before_rst", 32'(bus.lcd_en), 32'd1);
        bus.io_lcd = '0;
        rst = 1'b1;
        #1;
        check("t4_en_async", 32'(bus.lcd_en), 32'd0);
        check("t4_status", bus.lcd_status, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        drive_go(1'b1, 8'h61);
        sb.push_back({1'b1, 8'h61});
        tick(1);
        bus.io_lcd[11] = 1'b0;
        tick(17);
        check("t4_busy_n18", 32'(bus.lcd_status[0]), 32'd1);
        tick(1);
        check("t4_busy_n19", 32'(bus.lcd_status[0]), 32'd0);
        check("t4_count", 32'(bus.lcd_status[15:8]), 32'd1);

        // GO held high for 100 cycles is a single request.
        drive_go(1'b1, 8'h70);
        sb.push_back({1'b1, 8'h70});
        tick(100);
        check("t5_held_count", 32'(bus.lcd_status[15:8]), 32'd2);
        check("t5_held_busy", 32'(bus.lcd_status[0]), 32'd0);
        bus.io_lcd[11] = 1'b0;
        tick(1);

        // Chained writes, each GO on the previous final EXEC cycle; count wraps.
        gaps = 0;
        for (int i = 0; i < 253; i++) begin
            drive_go(1'b1, 8'(i));
            sb.push_back({1'b1, 8'(i)});
            tick(1);
            if (bus.lcd_data !== 8'(i) || bus.lcd_status[0] !== 1'b1) gaps++;
            bus.io_lcd[11] = 1'b0;
            tick(17);
        end
        check("t5_chain_gaps", 32'(gaps), 32'd0);
        tick(1);
        check("t5_count_ff", 32'(bus.lcd_status[15:8]), 32'hFF);
        check("t5_idle_after_chain", 32'(bus.lcd_status[0]), 32'd0);
        drive_go(1'b1, 8'hA5);
        sb.push_back({1'b1, 8'hA5});
        tick(1);
        bus.io_lcd[11] = 1'b0;
        tick(18);
        check("t5_count_wrap", 32'(bus.lcd_status[15:8]), 32'd0);
        check("rw_const", 32'(bus.lcd_rw), 32'd0);
`endif

        tick(5);
        check("sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Character-LCD bus controller on the far side of the core's `io_lcd` output register. Load/store software writes a command word into `io_lcd`. This block detects a GO edge in that word and buffers one command. It then drives the HD44780-style 8-bit parallel write cycle with programmable setup, enable-pulse, hold and execution delays. A status word is returned for the load/store unit to map as a readable I/O address, so software can poll for busy and overflow instead of bit-banging timing.

## Interface
- `T_SETUP`, 2: cycles RS/DATA are stable before EN rises (≥1)
- `T_EN`, 12: cycles EN held high (≥1)
- `T_HOLD`, 2: cycles RS/DATA held after EN falls (≥1)
- `T_EXEC`, 2000: execution wait for normal commands/data (≥1)
- `T_CLEAR`, 82000: execution wait for clear/home commands (≥1)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high; one clock domain
- `io_lcd`  in  32  command word from LSU: [31] ON, [30] BLON, [12] CLR_OVF, [11] GO, [9] RS, [7:0] DATA
- `lcd_status`  out  32  [0] busy, [1] overflow (sticky), [15:8] completed-write count, rest 0
- `lcd_on`, `lcd_blon`  out  1  panel power / backlight
- `lcd_en`, `lcd_rs`, `lcd_rw`  out  1  LCD bus control; `lcd_rw` constant 0 (write-only)
- `lcd_data`  out  8  LCD data bus

## Operation
- Request = rising edge of `io_lcd[11]` versus registered previous value. Captures `{RS, DATA}` from the same cycle.
- One-deep pending buffer.
- A request is dropped and overflow is set when the buffer is full and not consumed that cycle. A request in the same cycle the buffer is consumed is accepted.
- Overflow is cleared on a rising edge of `io_lcd[12]`. Set wins over clear in the same cycle.
- FSM states:
  - IDLE: bus idle, `lcd_en`=0.
  - SETUP: drive `lcd_rs`/`lcd_data`; lasts T_SETUP cycles.
  - PULSE: `lcd_en`=1; lasts T_EN cycles.
  - HOLD: `lcd_en`=0, bus held; lasts T_HOLD cycles.
  - EXEC: lasts T_EXEC cycles, or T_CLEAR when RS=0 and DATA is 0x01 or 0x02.
- IDLE→SETUP on a request (bypassing the buffer) or when the buffer is valid.
- EXEC→SETUP if the buffer is valid or a request arrives on the final EXEC cycle; otherwise EXEC→IDLE.
- Completed count increments on the final EXEC cycle and wraps 255→0.
- busy = FSM not IDLE, or buffer valid.
- `lcd_rs`/`lcd_data` hold their last values in IDLE.
- `lcd_on`/`lcd_blon` are registered copies of `io_lcd[31:30]`, independent of the FSM.

## Timing
- Reset values: all outputs 0, FSM IDLE, buffer empty, count 0, GO/CLR edge registers 0.
- Reset asserted mid-transaction aborts it at once: `lcd_en` drops asynchronously and no count increment occurs.
- GO edge sampled in cycle N while IDLE:
  - SETUP (with busy=1) from N+1.
  - `lcd_en` high for cycles N+1+T_SETUP through N+T_SETUP+T_EN.
  - Back in IDLE at N+1+T_SETUP+T_EN+T_HOLD+Texec.
- Back-to-back buffered command: SETUP in the cycle after the final EXEC cycle, with no IDLE gap.
- GO held high is one request; a new request needs GO to go 0 then 1.
- `lcd_status` and `lcd_on`/`lcd_blon` are registered; 1-cycle latency from the causing event.

## Configuration
- `LCD_INIT_EN` defined:
  - After reset release, the FSM autonomously issues RS=0 commands 0x38, 0x0C, 0x01, 0x06 through the same state sequence; 0x01 uses T_CLEAR.
  - busy=1 throughout, and the count does not increment.
  - A user request during init goes to the buffer, with normal overflow rules.
  - The first user command starts after the 0x06 EXEC ends.
- Not defined: FSM starts in IDLE after reset and only user commands are issued.

## Test plan
Bench overrides T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_CLEAR=50; `LCD_INIT_EN` undefined except in the last test.
- Single data write (GO 0→1 at cycle N, RS=1, DATA=0x41) -> `lcd_en` high exactly cycles N+3..N+6; `lcd_data`=0x41 and `lcd_rs`=1 from N+1; busy clears at N+19; count=1.
- Clear command (RS=0, DATA=0x01) -> EXEC lasts 50 cycles; busy clears at N+59.
- Three GO edges during one transaction -> second buffered and issued back-to-back; third dropped with overflow=1; count=2. CLR_OVF edge -> overflow=0.
- Assert `rst` during PULSE -> `lcd_en`=0 immediately; status=0; next GO runs a normal full sequence.
- GO held high for 100 cycles -> exactly one transaction; count wraps 0xFF→0x00 after 256 writes.
- With `LCD_INIT_EN` defined, reset release -> four EN pulses with DATA 0x38, 0x0C, 0x01, 0x06; busy=1 until done; count=0.
